// File: rtl/riscv_dmem_resp_if.sv
// Data-memory request/response bundle between the multicycle control unit
// (requester) and the data-memory responder.
interface riscv_dmem_resp_if;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output mem_re, mem_we, addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  mem_re, mem_we, addr, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: accepts one access per strobe assertion, waits a
// fixed latency, then returns read data with a one-cycle done pulse and error flag.
module riscv_dmem_resp #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic               clk,
  input  logic               reset,
  riscv_dmem_resp_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [31:0]            wdata_q;
  logic                   re_q, we_q, err_q;

  logic [31:0]            rdata_r;
  logic                   busy_r, done_r, err_r;

  logic [31:0]            mem [DEPTH] = '{default: '0};

  logic                   strobe_c, accept_c, enter_resp_c, live_err_c;
  logic [DEPTH_LOG2-1:0]  sel_idx_c;
  logic [31:0]            sel_wdata_c;
  logic                   sel_re_c, sel_we_c, sel_err_c;

  assign strobe_c   = bus.mem_re | bus.mem_we;
  assign accept_c   = (state == IDLE) && strobe_c;
  assign live_err_c = (|bus.addr[1:0]) | (|bus.addr[31:DEPTH_LOG2+2]) |
                      (bus.mem_re & bus.mem_we);

  // With LATENCY==1 the access completes at the accept edge, so use the live request.
  assign sel_idx_c    = (state == IDLE) ? bus.addr[DEPTH_LOG2+1:2] : idx_q;
  assign sel_wdata_c  = (state == IDLE) ? bus.wdata  : wdata_q;
  assign sel_re_c     = (state == IDLE) ? bus.mem_re : re_q;
  assign sel_we_c     = (state == IDLE) ? bus.mem_we : we_q;
  assign sel_err_c    = (state == IDLE) ? live_err_c : err_q;
  assign enter_resp_c = (state_nxt == RESP);

  // Next-state and latency counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: state_nxt = strobe_c ? HOLD : IDLE;
      HOLD: if (!strobe_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_r <= (state_nxt == WAIT) || (state_nxt == RESP);
      done_r <= enter_resp_c;
      err_r  <= enter_resp_c && sel_err_c;
      if (accept_c) begin
        idx_q   <= bus.addr[DEPTH_LOG2+1:2];
        wdata_q <= bus.wdata;
        re_q    <= bus.mem_re;
        we_q    <= bus.mem_we;
        err_q   <= live_err_c;
      end
      if (enter_resp_c && sel_re_c)
        rdata_r <= sel_err_c ? 32'h0 : mem[sel_idx_c];
    end
  end

  // A reset edge that would have completed a store discards it
  always_ff @(posedge clk) begin
    if (!reset && enter_resp_c && sel_we_c && !sel_err_c)
      mem[sel_idx_c] <= sel_wdata_c;
  end

  assign bus.rdata = rdata_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Directed bench for riscv_dmem_resp: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for the short-latency path.
module tb_riscv_dmem_resp;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  riscv_dmem_resp_if bus_a ();
  riscv_dmem_resp_if bus_b ();

  riscv_dmem_resp #(.DEPTH_LOG2(8), .LATENCY(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  riscv_dmem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic re, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      bus_b.mem_re = re; bus_b.mem_we = we; bus_b.addr = a; bus_b.wdata = d;
    end else begin
      bus_a.mem_re = re; bus_a.mem_we = we; bus_a.addr = a; bus_a.wdata = d;
    end
  endtask

  function automatic logic obs_done(input bit sel);
    return sel ? bus_b.done : bus_a.done;
  endfunction

  function automatic logic obs_busy(input bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction

  // Issue a request and check done rises exactly at the expected edge; strobes stay asserted.
  task automatic access(input bit sel, input logic re, input logic we,
                        input logic [31:0] a, input logic [31:0] d, input int lat);
    drive(sel, re, we, a, d);
    step();
    for (int k = 1; k < lat; k++) begin
      chk("done_early", 32'(obs_done(sel)), 32'h0);
      chk("busy_wait",  32'(obs_busy(sel)), 32'h1);
      step();
    end
    chk("done_pulse", 32'(obs_done(sel)), 32'h1);
    chk("busy_resp",  32'(obs_busy(sel)), 32'h1);
  endtask

  initial begin
    int pulses;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;

    chk("rst_rdata", bus_a.rdata, 32'h0);
    chk("rst_busy",  32'(bus_a.busy), 32'h0);
    chk("rst_done",  32'(bus_a.done), 32'h0);
    chk("rst_err",   32'(bus_a.err), 32'h0);
    chk("rst_done_b", 32'(bus_b.done), 32'h0);

    // Write then read
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2);
    chk("wr_err", 32'(bus_a.err), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("wr_after_done", 32'(bus_a.done), 32'h0);
    chk("wr_after_busy", 32'(bus_a.busy), 32'h0);

    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2);
    chk("rd_rdata", bus_a.rdata, 32'hDEADBEEF);
    chk("rd_err", 32'(bus_a.err), 32'h0);

    // Held strobe: no further pulses while sitting in HOLD
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (bus_a.done) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 32'h0);
    chk("hold_busy", 32'(bus_a.busy), 32'h0);
    chk("hold_rdata", bus_a.rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2);
    chk("rearm_rdata", bus_a.rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Misaligned write is rejected and leaves memory and rdata alone
    access(1'b0, 1'b0, 1'b1, 32'h12, 32'h1, 2);
    chk("mis_err", 32'(bus_a.err), 32'h1);
    chk("mis_rdata_hold", bus_a.rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("err_unqualified", 32'(bus_a.err), 32'h0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2);
    chk("mis_readback", bus_a.rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Out of range read
    access(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 2);
    chk("oor_err", 32'(bus_a.err), 32'h1);
    chk("oor_rdata", bus_a.rdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Simultaneous strobes: error, no store
    access(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 2);
    chk("both_err", 32'(bus_a.err), 32'h1);
    chk("both_rdata", bus_a.rdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2);
    chk("both_readback", bus_a.rdata, 32'h0);
    chk("both_readback_err", 32'(bus_a.err), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Strobe dropped during WAIT: still completes, then returns to IDLE
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("drop_done", 32'(bus_a.done), 32'h1);
    step();
    chk("drop_idle_done", 32'(bus_a.done), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    chk("drop_reaccept_busy", 32'(bus_a.busy), 32'h1);
    step();
    chk("drop_reaccept_done", 32'(bus_a.done), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset during WAIT aborts the store
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h55);
    step();
    chk("rstmid_busy_before", 32'(bus_a.busy), 32'h1);
    reset = 1'b1;
    step();
    chk("rstmid_done", 32'(bus_a.done), 32'h0);
    chk("rstmid_busy", 32'(bus_a.busy), 32'h0);
    chk("rstmid_err", 32'(bus_a.err), 32'h0);
    chk("rstmid_rdata", bus_a.rdata, 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 2);
    chk("rstmid_readback", bus_a.rdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // LATENCY=1 instance
    access(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1);
    chk("lat1_rdata", bus_b.rdata, 32'h0);
    chk("lat1_err", 32'(bus_b.err), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("lat1_done_low", 32'(bus_b.done), 32'h0);
    access(1'b1, 1'b0, 1'b1, 32'h4, 32'hA5, 1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1);
    chk("lat1_readback", bus_b.rdata, 32'hA5);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
